// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer commit/swap block and its status readback word.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } fb_state_t;

  localparam logic [31:0] BUF0_BASE_DEF = 32'h3000_0000;
  localparam logic [31:0] BUF1_BASE_DEF = 32'h3020_0000;

  localparam int OVR_W = 8;

  // Status word layout seen by software through the companion input PIO.
  localparam int ST_FRONT_SEL_BIT = 0;
  localparam int ST_PENDING_BIT   = 1;
  localparam int ST_OVR_LSB       = 8;
  localparam int ST_FRAME_LSB     = 16;

  function automatic logic [31:0] pack_status(input logic             front_sel,
                                              input logic             pending,
                                              input logic [OVR_W-1:0] ovr,
                                              input logic [15:0]      frame);
    logic [31:0] w;
    w                          = '0;
    w[ST_FRONT_SEL_BIT]        = front_sel;
    w[ST_PENDING_BIT]          = pending;
    w[ST_OVR_LSB +: OVR_W]     = ovr;
    w[ST_FRAME_LSB +: 16]      = frame;
    return w;
  endfunction

endpackage

// File: rtl/fb_sync_edge.sv
// Synchroniser for a toggle-protocol input plus registered any-edge detector.
// Latency: a change sampled at edge k gives toggle_pulse high after edge k+STAGES; no backpressure.
module fb_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic toggle_pulse
);

  logic [STAGES-1:0] sync_q;
  logic              sync_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      sync_d       <= 1'b0;
      toggle_pulse <= 1'b0;
    end else begin
      sync_q       <= {sync_q[STAGES-2:0], din};
      sync_d       <= sync_q[STAGES-1];
      // Either polarity of the software toggle counts as one commit.
      toggle_pulse <= sync_q[STAGES-1] ^ sync_d;
    end
  end

endmodule

// File: rtl/fb_commit_swap.sv
// Holds a software buffer-complete commit and swaps front/back framebuffer bases on the next vsync rise.
// Latency: commit_in change to commit_pending is SYNC_STAGES+1 edges; swap lands on the vsync edge; no backpressure.
module fb_commit_swap
  import fb_pkg::*;
#(
  parameter logic [31:0] BUF0_BASE   = BUF0_BASE_DEF,
  parameter logic [31:0] BUF1_BASE   = BUF1_BASE_DEF,
  parameter int          SYNC_STAGES = 2,
  parameter int          FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   commit_in,
  input  logic                   vsync,
  output logic [31:0]            front_base,
  output logic [31:0]            back_base,
  output logic                   front_sel,
  output logic                   swap_pulse,
  output logic                   commit_pending,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [OVR_W-1:0]       overrun_count
);

  fb_state_t state, state_nxt;
  logic      commit_edge;
  logic      vsync_d;
  logic      vs_rise;
  logic      ovr_inc;
  logic      sel_toggle;

  fb_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_commit_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (commit_in),
    .toggle_pulse(commit_edge)
  );

  // vsync is already in the clk domain, so only a single delay flop is needed.
  assign vs_rise = vsync & ~vsync_d;

  always_comb begin
    state_nxt  = state;
    ovr_inc    = 1'b0;
    sel_toggle = 1'b0;
    case (state)
      ST_IDLE: begin
        if (commit_edge) state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        ovr_inc = commit_edge;
        if (vs_rise) begin
          state_nxt  = ST_SWAP;
          sel_toggle = 1'b1;
        end
      end
      ST_SWAP: begin
        state_nxt = commit_edge ? ST_PENDING : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      vsync_d       <= 1'b0;
      front_sel     <= 1'b0;
      front_base    <= BUF0_BASE;
      back_base     <= BUF1_BASE;
      frame_count   <= '0;
      overrun_count <= '0;
    end else begin
      state   <= state_nxt;
      vsync_d <= vsync;
      if (vs_rise) frame_count <= frame_count + FRAME_CNT_W'(1);
      if (ovr_inc && (overrun_count != {OVR_W{1'b1}}))
        overrun_count <= overrun_count + OVR_W'(1);
      // Bases follow the new selection on the swap edge so they are valid alongside swap_pulse.
      if (sel_toggle) begin
        front_sel  <= ~front_sel;
        front_base <= front_sel ? BUF0_BASE : BUF1_BASE;
        back_base  <= front_sel ? BUF1_BASE : BUF0_BASE;
      end
    end
  end

  assign commit_pending = (state == ST_PENDING);
  assign swap_pulse     = (state == ST_SWAP);

endmodule
